// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse decoder: length limits, FSM state
// encodings and the pulse-length to numero mapping.
package pulse_pkg;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;

  typedef logic [CNT_W-1:0] len_t;

  localparam len_t MAX_LEN_L = len_t'(MAX_LEN);
  localparam len_t CNT_SAT   = '1;

  typedef enum logic [1:0] {
    W_LOW,
    IDLE,
    COUNT
  } meter_state_t;

  typedef enum logic {
    EMPTY,
    OFFER
  } offer_state_t;

  // Legal lengths are the even values 2..MAX_LEN; the saturated count is
  // always above MAX_LEN, so it lands in the illegal set as well.
  function automatic logic is_legal_len(input len_t len);
    return (len[0] == 1'b0) && (len != '0) && (len <= MAX_LEN_L);
  endfunction

  function automatic logic [1:0] len_to_numero(input len_t len);
    len_t half;
    half = len >> 1;
    return 2'(half - len_t'(1));
  endfunction

endpackage

// File: rtl/pulse_meter.sv
// Measures each high pulse on the input line and reports the decoded value
// for one cycle on the edge that samples the falling edge of the pulse.
module pulse_meter
  import pulse_pkg::*;
(
  input  logic       clock,
  input  logic       reset_,
  input  logic       in,
  output logic       res_valid,
  output logic [1:0] res,
  output logic       err
);

  meter_state_t state;
  len_t         cnt;

  // The result is combinational so the buffer can capture it on the very
  // edge that samples the end of the pulse.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    res_valid = 1'b0;
    res       = len_to_numero(cnt);
    if (state == COUNT && !in && is_legal_len(cnt)) begin
      res_valid = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state <= W_LOW;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        W_LOW: begin
          // Skip whatever pulse was already running when reset was released.
          if (!in) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (in) begin
            cnt   <= len_t'(1);
            state <= COUNT;
          end
        end
        COUNT: begin
          if (in) begin
            if (cnt != CNT_SAT) begin
              cnt <= cnt + len_t'(1);
            end
          end else begin
            err   <= !is_legal_len(cnt);
            state <= IDLE;
          end
        end
        default: begin
          state <= W_LOW;
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_decoder.sv
// Recovers numero from the pulse generator's output and offers it to a
// consumer over the dav_/rfd handshake through a single-entry buffer.
module pulse_decoder
  import pulse_pkg::*;
(
  input  logic       clock,
  input  logic       reset_,
  input  logic       in,
  input  logic       rfd,
  output logic [1:0] numero,
  output logic       dav_,
  output logic       err,
  output logic       ovr
);

  logic         meter_valid;
  logic [1:0]   meter_res;
  logic         freeing;
  logic         buf_valid;
  logic [1:0]   buf_data;
  offer_state_t offer_state;

  pulse_meter u_meter (
    .clock     (clock),
    .reset_    (reset_),
    .in        (in),
    .res_valid (meter_valid),
    .res       (meter_res),
    .err       (err)
  );

  // The buffer is released on the edge where the consumer drops rfd.
  always_comb begin
    freeing = (offer_state == OFFER) && !rfd;
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      // NOTE: the one-entry buffer is a plain register with its own valid
      // flag, so it is reset alongside the FSM rather than left uninitialised.
      offer_state <= EMPTY;
      buf_valid   <= 1'b0;
      buf_data    <= '0;
      numero      <= '0;
      dav_        <= 1'b1;
      ovr         <= 1'b0;
    end else begin
      ovr <= 1'b0;

      case (offer_state)
        EMPTY: begin
          if (buf_valid && rfd) begin
            numero      <= buf_data;
            dav_        <= 1'b0;
            offer_state <= OFFER;
          end
        end
        OFFER: begin
          if (!rfd) begin
            dav_        <= 1'b1;
            offer_state <= EMPTY;
          end
        end
      endcase

      // A new result may take the slot that is being freed on this edge;
      // otherwise it is dropped and the held value survives.
      if (meter_valid) begin
        if (!buf_valid || freeing) begin
          buf_data  <= meter_res;
          buf_valid <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (freeing) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_decoder.sv
// Directed and randomized bench for pulse_decoder, checked every cycle
// against a behavioural model of pulse lengths and a one-slot result queue.
module tb_pulse_decoder;

  logic       clock;
  logic       reset_;
  logic       in_s;
  logic       rfd;
  logic [1:0] numero;
  logic       dav_;
  logic       err;
  logic       ovr;

  int checks = 0;
  int fails  = 0;

  // Behavioural model state.
  bit         armed;
  int         run_len;
  bit         offering;
  logic [1:0] pend_q[$];
  logic [1:0] exp_num;
  logic       exp_dav;
  logic       exp_err;
  logic       exp_ovr;

  // Observation bookkeeping for the directed steps.
  int         err_seen;
  int         ovr_seen;
  logic       prev_dav;
  logic [1:0] delivered[$];

  pulse_decoder dut (
    .clock  (clock),
    .reset_ (reset_),
    .in     (in_s),
    .rfd    (rfd),
    .numero (numero),
    .dav_   (dav_),
    .err    (err),
    .ovr    (ovr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the sampled inputs of one rising edge to the model.
  task automatic model_edge(input logic i, input logic r, input logic rs);
    bit         free_now;
    bit         start_now;
    bit         has_new;
    logic [1:0] new_val;
    int         len;
    if (!rs) begin
      armed    = 0;
      run_len  = 0;
      offering = 0;
      pend_q.delete();
      exp_num  = 2'd0;
      exp_dav  = 1'b1;
      exp_err  = 1'b0;
      exp_ovr  = 1'b0;
      return;
    end
    exp_err   = 1'b0;
    exp_ovr   = 1'b0;
    has_new   = 0;
    new_val   = 2'd0;
    free_now  = offering && !r;
    start_now = !offering && (pend_q.size() > 0) && r;
    if (!armed) begin
      if (!i) armed = 1;
    end else if (i) begin
      run_len++;
    end else if (run_len > 0) begin
      len     = run_len;
      run_len = 0;
      if ((len % 2 == 0) && len >= 2 && len <= 8) begin
        has_new = 1;
        new_val = 2'(len / 2 - 1);
      end else begin
        exp_err = 1'b1;
      end
    end
    if (start_now) begin
      exp_num  = pend_q[0];
      exp_dav  = 1'b0;
      offering = 1;
    end
    if (free_now) begin
      exp_dav  = 1'b1;
      offering = 0;
      void'(pend_q.pop_front());
    end
    if (has_new) begin
      if (pend_q.size() == 0) pend_q.push_back(new_val);
      else exp_ovr = 1'b1;
    end
  endtask

  // One clock: model the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clock);
    model_edge(in_s, rfd, reset_);
    @(negedge clock);
    check("dav_", dav_, exp_dav);
    check("numero", numero, exp_num);
    check("err", err, exp_err);
    check("ovr", ovr, exp_ovr);
    if (err === 1'b1) err_seen++;
    if (ovr === 1'b1) ovr_seen++;
    if (prev_dav === 1'b1 && dav_ === 1'b0) delivered.push_back(numero);
    prev_dav = dav_;
  endtask

  task automatic idle(input int n);
    in_s = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // High for len cycles, then the evaluation edge that samples the low.
  task automatic pulse(input int len);
    in_s = 1'b1;
    for (int k = 0; k < len; k++) tick();
    in_s = 1'b0;
    tick();
  endtask

  task automatic release_rfd();
    rfd = 1'b0;
    tick();
    rfd = 1'b1;
  endtask

  initial begin
    logic [1:0] want[3];
    int         lens[3];
    int         len;
    int         gap;
    want = '{2'd1, 2'd2, 2'd3};
    lens = '{4, 6, 8};

    prev_dav = 1'b1;
    err_seen = 0;
    ovr_seen = 0;
    reset_   = 1'b0;
    in_s     = 1'b0;
    rfd      = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("rst_dav", dav_, 1'b1);
    check("rst_numero", numero, 2'd0);
    reset_ = 1'b1;
    idle(2);
    check("idle_dav", dav_, 1'b1);
    check("idle_err", err, 1'b0);
    check("idle_ovr", ovr, 1'b0);

    // Shortest legal pulse.
    pulse(2);
    tick();
    check("p2_dav", dav_, 1'b0);
    check("p2_numero", numero, 2'd0);
    release_rfd();
    check("p2_release", dav_, 1'b1);

    // 4, 6, 8 cycle pulses, each fully handshaken.
    err_seen = 0;
    delivered.delete();
    for (int n = 0; n < 3; n++) begin
      pulse(lens[n]);
      tick();
      check("lens_dav", dav_, 1'b0);
      check("lens_numero", numero, want[n]);
      release_rfd();
      tick();
    end
    check("lens_count", 8'(delivered.size()), 8'd3);
    check("lens_err", 8'(err_seen), 8'd0);

    // Malformed lengths: odd and too long.
    err_seen = 0;
    pulse(3);
    check("p3_err", err, 1'b1);
    idle(2);
    pulse(10);
    check("p10_err", err, 1'b1);
    idle(2);
    check("bad_err_count", 8'(err_seen), 8'd2);
    check("bad_dav", dav_, 1'b1);

    // Consumer stalled: second result overflows, first survives.
    ovr_seen = 0;
    rfd = 1'b0;
    pulse(2);
    idle(1);
    pulse(2);
    check("ovr_pulse", ovr, 1'b1);
    idle(2);
    check("ovr_count", 8'(ovr_seen), 8'd1);
    check("ovr_dav_held", dav_, 1'b1);
    rfd = 1'b1;
    tick();
    check("ovr_deliver_dav", dav_, 1'b0);
    check("ovr_deliver_num", numero, 2'd0);
    release_rfd();

    // Stalled again with a different dropped value: the kept one is 00.
    rfd = 1'b0;
    pulse(2);
    idle(1);
    pulse(8);
    idle(1);
    rfd = 1'b1;
    tick();
    check("ovr2_num", numero, 2'd0);
    release_rfd();
    idle(3);
    check("ovr2_nothing_left", dav_, 1'b1);

    // Pulse ends on the same edge the handshake releases.
    ovr_seen = 0;
    pulse(2);
    tick();
    check("same_pre_dav", dav_, 1'b0);
    in_s = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    in_s = 1'b0;
    rfd  = 1'b0;
    tick();
    check("same_dav_high", dav_, 1'b1);
    check("same_no_ovr", ovr, 1'b0);
    rfd = 1'b1;
    tick();
    check("same_next_dav", dav_, 1'b0);
    check("same_next_num", numero, 2'd1);
    release_rfd();
    check("same_ovr_count", 8'(ovr_seen), 8'd0);

    // Reset mid-handshake and mid-pulse.
    err_seen = 0;
    pulse(2);
    tick();
    check("mid_offer_dav", dav_, 1'b0);
    in_s = 1'b1;
    tick();
    tick();
    reset_ = 1'b0;
    tick();
    check("mid_rst_dav", dav_, 1'b1);
    check("mid_rst_num", numero, 2'd0);
    reset_ = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    idle(2);
    check("mid_no_err", 8'(err_seen), 8'd0);
    check("mid_dav", dav_, 1'b1);
    pulse(4);
    tick();
    check("mid_after_num", numero, 2'd1);
    check("mid_after_dav", dav_, 1'b0);
    release_rfd();
    idle(1);

    // Randomized traffic with a randomly ready consumer.
    for (int p = 0; p < 60; p++) begin
      len = int'($urandom_range(1, 11));
      gap = int'($urandom_range(1, 4));
      in_s = 1'b1;
      for (int k = 0; k < len; k++) begin
        rfd = 1'($urandom_range(0, 1));
        tick();
      end
      in_s = 1'b0;
      for (int k = 0; k < gap; k++) begin
        rfd = 1'($urandom_range(0, 1));
        tick();
      end
    end
    rfd = 1'b1;
    idle(3);
    rfd = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
